// File: rtl/dm_ctrl_pkg.sv
// rtl/dm_ctrl_pkg.sv - shared constants, state encoding and helpers for the data-memory controller
package dm_ctrl_pkg;

    localparam int DM_DATA_W = 32;
    localparam int DM_TYPE_W = 3;
    localparam int DM_ADDR_W = 9;

    localparam logic [DM_TYPE_W-1:0] DM_WORD   = 3'b000;
    localparam logic [DM_TYPE_W-1:0] DM_HALF   = 3'b001;
    localparam logic [DM_TYPE_W-1:0] DM_HALF_U = 3'b010;
    localparam logic [DM_TYPE_W-1:0] DM_BYTE   = 3'b011;
    localparam logic [DM_TYPE_W-1:0] DM_BYTE_U = 3'b100;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_EXT   = 3'd2;
    localparam logic [2:0] ST_MERGE = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Illegal access type, or an address not aligned to the access size.
    function automatic logic dm_access_err(input logic [DM_TYPE_W-1:0] dm_type,
                                           input logic [1:0] lsb);
        case (dm_type)
            DM_WORD:              return lsb != 2'b00;
            DM_HALF, DM_HALF_U:   return lsb[0];
            DM_BYTE, DM_BYTE_U:   return 1'b0;
            default:              return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// rtl/dm_ctrl_if.sv - request/response bundle between the CPU data port and dm_ctrl
interface dm_ctrl_if import dm_ctrl_pkg::*; #(
    parameter int ADDR_W = DM_ADDR_W
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic                 mem_w;
    logic [ADDR_W-1:0]    addr;
    logic [DM_TYPE_W-1:0] dmType;
    logic [DM_DATA_W-1:0] wdata;
    logic [DM_DATA_W-1:0] rdata;
    logic                 done;
    logic                 err;

    modport master (
        output req_valid, mem_w, addr, dmType, wdata,
        input  req_ready, rdata, done, err
    );

    modport slave (
        input  req_valid, mem_w, addr, dmType, wdata,
        output req_ready, rdata, done, err
    );
endinterface

// File: rtl/dm_word_ram.sv
// rtl/dm_word_ram.sv - single-port word RAM, registered read, no reset
module dm_word_ram import dm_ctrl_pkg::*; #(
    parameter int ADDR_W    = DM_ADDR_W,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 we,
    input  logic [ADDR_W-3:0]    waddr,
    input  logic [DM_DATA_W-1:0] din,
    output logic [DM_DATA_W-1:0] dout
);
    localparam int DEPTH = 1 << (ADDR_W - 2);

    generate
        if (INIT_ZERO) begin : g_zero
            logic [DM_DATA_W-1:0] mem [DEPTH] = '{default: '0};

            // One access per cycle: write when we, otherwise register the read word.
            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) mem[waddr] <= din;
                    else    dout       <= mem[waddr];
                end
            end
        end else begin : g_noinit
            logic [DM_DATA_W-1:0] mem [DEPTH];

            // One access per cycle: write when we, otherwise register the read word.
            always_ff @(posedge clk) begin
                if (en) begin
                    if (we) mem[waddr] <= din;
                    else    dout       <= mem[waddr];
                end
            end
        end
    endgenerate
endmodule

// File: rtl/dm_ctrl.sv
// rtl/dm_ctrl.sv - data-memory access controller with sub-word RMW stores and load extension
module dm_ctrl import dm_ctrl_pkg::*; #(
    parameter int ADDR_W    = DM_ADDR_W,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic   clk,
    input  logic   reset,
    dm_ctrl_if.slave bus
);
    logic [2:0]           state;
    logic                 mem_w_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [DM_TYPE_W-1:0] type_q;
    logic [DM_DATA_W-1:0] wdata_q;
    logic                 err_q;
    logic [DM_DATA_W-1:0] rdata_q;

    logic                 accept;
    logic                 acc_err;
    logic                 ram_en;
    logic                 ram_we;
    logic [DM_DATA_W-1:0] ram_din;
    logic [DM_DATA_W-1:0] ram_dout;
    logic [DM_DATA_W-1:0] shifted;
    logic [7:0]           byte_lane;
    logic [15:0]          half_lane;
    logic [DM_DATA_W-1:0] ext_word;
    logic [DM_DATA_W-1:0] merged;

    assign accept  = bus.req_valid && (state == ST_IDLE);
    assign acc_err = dm_access_err(bus.dmType, bus.addr[1:0]);

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.err       = (state == ST_DONE) && err_q;
    assign bus.rdata     = rdata_q;

    // RAM is touched only in RD (read) and MERGE/WR (write); reset forces IDLE so no write slips through.
    assign ram_en  = (state == ST_RD) || (state == ST_MERGE) || (state == ST_WR);
    assign ram_we  = (state == ST_MERGE) || (state == ST_WR);
    assign ram_din = (state == ST_WR) ? wdata_q : merged;

    dm_word_ram #(
        .ADDR_W    (ADDR_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .waddr (addr_q[ADDR_W-1:2]),
        .din   (ram_din),
        .dout  (ram_dout)
    );

    // Lane extraction with sign/zero extension, and lane replacement for sub-word stores.
    always_comb begin
        shifted   = ram_dout >> {addr_q[1:0], 3'b000};
        byte_lane = shifted[7:0];
        half_lane = addr_q[1] ? ram_dout[31:16] : ram_dout[15:0];
        ext_word  = ram_dout;
        merged    = ram_dout;
        case (type_q)
            DM_HALF:   ext_word = {{16{half_lane[15]}}, half_lane};
            DM_HALF_U: ext_word = {16'h0000, half_lane};
            DM_BYTE:   ext_word = {{24{byte_lane[7]}}, byte_lane};
            DM_BYTE_U: ext_word = {24'h000000, byte_lane};
            default:   ext_word = ram_dout;
        endcase
        case (type_q)
            DM_HALF, DM_HALF_U: merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            DM_BYTE, DM_BYTE_U: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            default:            merged = ram_dout;
        endcase
    end

    // Controller FSM: capture on accept, then sequence read / extend / merge / write / done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            mem_w_q <= 1'b0;
            addr_q  <= '0;
            type_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mem_w_q <= bus.mem_w;
                        addr_q  <= bus.addr;
                        type_q  <= bus.dmType;
                        wdata_q <= bus.wdata;
                        err_q   <= acc_err;
                        if (acc_err)
                            state <= ST_DONE;
                        else if (bus.mem_w && (bus.dmType == DM_WORD))
                            state <= ST_WR;
                        else
                            state <= ST_RD;
                    end
                end
                ST_RD:    state <= mem_w_q ? ST_MERGE : ST_EXT;
                ST_EXT: begin
                    rdata_q <= ext_word;
                    state   <= ST_DONE;
                end
                ST_MERGE: state <= ST_DONE;
                ST_WR:    state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_ctrl.sv
// tb/tb_dm_ctrl.sv - self-checking bench for dm_ctrl against a byte-array reference model
module tb_dm_ctrl;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    dm_ctrl_if bus ();

    dm_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  ref_bytes [512];
    logic [31:0] ref_rdata;

    // Reference: access size from type, alignment by modulo, memory as a byte array.
    function automatic void ref_apply(input bit w, input logic [8:0] a, input logic [2:0] t,
                                      input logic [31:0] d, output bit e, output int lat);
        int size;
        logic [31:0] v;
        size = (t == 3'd0) ? 4 : (t == 3'd1 || t == 3'd2) ? 2 : (t == 3'd3 || t == 3'd4) ? 1 : 0;
        e = (size == 0) || ((int'(a) % size) != 0);
        if (e) begin
            lat = 1;
            return;
        end
        if (w) begin
            for (int k = 0; k < size; k++) ref_bytes[int'(a) + k] = d[8*k +: 8];
            lat = (size == 4) ? 2 : 3;
        end else begin
            v = 0;
            for (int k = 0; k < size; k++) v = v | (32'(ref_bytes[int'(a) + k]) << (8*k));
            if (t == 3'd1 && v[15]) v = v | 32'hFFFF0000;
            if (t == 3'd3 && v[7])  v = v | 32'hFFFFFF00;
            ref_rdata = v;
            lat = 3;
        end
    endfunction

    // Drive one request, scramble inputs after accept, and measure latency to done.
    task automatic run_op(input bit w, input logic [8:0] a, input logic [2:0] t, input logic [31:0] d,
                          output int lat, output logic e, output logic [31:0] rd);
        int waitc;
        lat = -1;
        e = 1'bx;
        rd = 32'hx;
        @(negedge clk);
        bus.mem_w = w; bus.addr = a; bus.dmType = t; bus.wdata = d; bus.req_valid = 1'b1;
        waitc = 0;
        while (!bus.req_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (!bus.req_ready) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.mem_w = 1'($urandom); bus.addr = 9'($urandom); bus.dmType = 3'($urandom); bus.wdata = $urandom;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                e = bus.err;
                rd = bus.rdata;
                return;
            end
        end
    endtask

    task automatic test_reset;
        bus.req_valid = 1'b0; bus.mem_w = 1'b0; bus.addr = '0; bus.dmType = '0; bus.wdata = '0;
        reset = 1'b1;
        for (int i = 0; i < 512; i++) ref_bytes[i] = 8'h00;
        ref_rdata = 32'h0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata); end
        reset = 1'b0;
    endtask

    // One directed op, compared against literal expectations while keeping the model in sync.
    task automatic directed(input string name, input bit w, input logic [8:0] a, input logic [2:0] t,
                            input logic [31:0] d, input int exp_lat, input logic exp_e, input logic [31:0] exp_rd);
        int lat; logic e; logic [31:0] rd; bit me; int ml;
        ref_apply(w, a, t, d, me, ml);
        run_op(w, a, t, d, lat, e, rd);
        n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL %s_lat got=%0d exp=%0d", name, lat, exp_lat); end
        n_cmp++; if (e !== exp_e) begin n_bad++; $display("FAIL %s_err got=%b exp=%b", name, e, exp_e); end
        n_cmp++; if (rd !== exp_rd) begin n_bad++; $display("FAIL %s_rdata got=%h exp=%h", name, rd, exp_rd); end
    endtask

    task automatic test_word_and_subword;
        directed("sw",  1, 9'h010, 3'd0, 32'h12345678, 2, 0, 32'h00000000);
        directed("lw",  0, 9'h010, 3'd0, 32'h0,        3, 0, 32'h12345678);
        directed("sb",  1, 9'h011, 3'd3, 32'h000000AB, 3, 0, 32'h12345678);
        directed("lw2", 0, 9'h010, 3'd0, 32'h0,        3, 0, 32'h1234AB78);
        directed("lb",  0, 9'h011, 3'd3, 32'h0,        3, 0, 32'hFFFFFFAB);
        directed("lbu", 0, 9'h011, 3'd4, 32'h0,        3, 0, 32'h000000AB);
        directed("sh",  1, 9'h012, 3'd1, 32'h00008001, 3, 0, 32'h000000AB);
        directed("lw3", 0, 9'h010, 3'd0, 32'h0,        3, 0, 32'h8001AB78);
        directed("lh",  0, 9'h012, 3'd1, 32'h0,        3, 0, 32'hFFFF8001);
        directed("lhu", 0, 9'h012, 3'd2, 32'h0,        3, 0, 32'h00008001);
    endtask

    task automatic test_errors;
        directed("lw_mis",  0, 9'h013, 3'd0, 32'h0,        1, 1, 32'h00008001);
        directed("sh_mis",  1, 9'h011, 3'd1, 32'hDEADBEEF, 1, 1, 32'h00008001);
        directed("bad_typ", 1, 9'h010, 3'd6, 32'hDEADBEEF, 1, 1, 32'h00008001);
        directed("lw_after",0, 9'h010, 3'd0, 32'h0,        3, 0, 32'h8001AB78);
    endtask

    task automatic test_reset_abort;
        bit me; int ml;
        directed("pre_sw", 1, 9'h014, 3'd0, 32'h11223344, 2, 0, 32'h8001AB78);
        @(negedge clk);
        bus.mem_w = 1'b1; bus.addr = 9'h014; bus.dmType = 3'd3; bus.wdata = 32'h000000FF; bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got=%b exp=1", bus.req_ready); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_done got=%b exp=0", bus.done); end
        n_cmp++; if (bus.rdata !== 32'h0) begin n_bad++; $display("FAIL abort_rdata got=%h exp=0", bus.rdata); end
        @(negedge clk);
        reset = 1'b0;
        ref_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done got=%b exp=0", bus.done); end
        end
        ref_apply(1'b0, 9'h014, 3'd0, 32'h0, me, ml);
        directed("abort_lw", 0, 9'h014, 3'd0, 32'h0, 3, 0, 32'h11223344);
    endtask

    task automatic test_back_to_back;
        bit          ow [4];
        logic [8:0]  oa [4];
        logic [2:0]  ot [4];
        logic [31:0] od [4];
        int lat; int exp_lat; bit exp_e; bit busy_ready;
        ow = '{1, 0, 1, 0};
        ot = '{3'd0, 3'd3, 3'd1, 3'd0};
        od[0] = $urandom; od[1] = 0; od[2] = $urandom; od[3] = 0;
        oa[0] = 9'(($urandom_range(16, 31)) * 4);
        oa[1] = oa[0] + 9'($urandom_range(0, 3));
        oa[2] = oa[0] + 9'(2 * $urandom_range(0, 1));
        oa[3] = oa[0];
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_done op=%0d got=%b exp=1", i, bus.req_ready); end
            end
            bus.mem_w = ow[i]; bus.addr = oa[i]; bus.dmType = ot[i]; bus.wdata = od[i]; bus.req_valid = 1'b1;
            ref_apply(ow[i], oa[i], ot[i], od[i], exp_e, exp_lat);
            @(posedge clk);
            lat = -1;
            busy_ready = 0;
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (bus.req_ready) busy_ready = 1;
                if (bus.done) begin
                    lat = n;
                    break;
                end
            end
            n_cmp++; if (lat !== exp_lat) begin n_bad++; $display("FAIL b2b_lat op=%0d got=%0d exp=%0d", i, lat, exp_lat); end
            n_cmp++; if (busy_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_ready op=%0d got=%b exp=0", i, busy_ready); end
            n_cmp++; if (bus.err !== exp_e) begin n_bad++; $display("FAIL b2b_err op=%0d got=%b exp=%b", i, bus.err, exp_e); end
            n_cmp++; if (bus.rdata !== ref_rdata) begin n_bad++; $display("FAIL b2b_rdata op=%0d got=%h exp=%h", i, bus.rdata, ref_rdata); end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_random;
        bit w; logic [8:0] a; logic [2:0] t; logic [31:0] d;
        int lat; logic e; logic [31:0] rd; bit me; int ml;
        for (int i = 0; i < 60; i++) begin
            w = 1'($urandom);
            t = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            a = 9'($urandom_range(32, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (t == 3'd0) a = a & 9'h1FC;
                else if (t == 3'd1 || t == 3'd2) a = a & 9'h1FE;
            end
            d = $urandom;
            ref_apply(w, a, t, d, me, ml);
            run_op(w, a, t, d, lat, e, rd);
            n_cmp++; if (lat !== ml) begin n_bad++; $display("FAIL rand_lat i=%0d got=%0d exp=%0d", i, lat, ml); end
            n_cmp++; if (e !== me) begin n_bad++; $display("FAIL rand_err i=%0d got=%b exp=%b", i, e, me); end
            n_cmp++; if (rd !== ref_rdata) begin n_bad++; $display("FAIL rand_rdata i=%0d got=%h exp=%h", i, rd, ref_rdata); end
        end
        for (int wi = 8; wi < 16; wi++) begin
            a = 9'(wi * 4);
            ref_apply(1'b0, a, 3'd0, 32'h0, me, ml);
            run_op(1'b0, a, 3'd0, 32'h0, lat, e, rd);
            n_cmp++; if (rd !== ref_rdata) begin n_bad++; $display("FAIL rand_sweep addr=%h got=%h exp=%h", a, rd, ref_rdata); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        test_reset;
        test_word_and_subword;
        test_errors;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
